// File: rtl/ps2_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 keyboard front end and display driver:
//   PS2_EXT / PS2_BRK   : extended-prefix and break-prefix scancode bytes
//   dec_state_t         : decode FSM states
//   hex_to_seg()        : 4-bit hex nibble -> 7-segment pattern {g..a},
//                         active-high (lit = 1); polarity is applied by the user.
// ----------------------------------------------------------------------------
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } dec_state_t;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// ----------------------------------------------------------------------------
// ps2_rx
// PS/2 device-to-host frame receiver.
//   i_clk        system clock
//   i_rst        synchronous reset, active-high
//   i_ps2_clk    PS/2 clock pin (asynchronous)
//   i_ps2_data   PS/2 data pin (asynchronous)
//   o_byte_rdy   1-cycle pulse: a good frame was received, o_byte_data valid
//   o_byte_data  received data byte (held until the next good frame)
//   o_frame_err  1-cycle pulse: bad start/stop/parity, or partial-frame timeout
// Both pins pass through 2-FF synchronisers; a third clock stage gives the
// falling-edge detect. Data is sampled from the synchronised data line, which
// is aligned with the synchronised clock's second stage.
// ----------------------------------------------------------------------------
module ps2_rx #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic       o_byte_rdy,
    output logic [7:0] o_byte_data,
    output logic       o_frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

    logic [2:0]    r_clk_sync;
    logic [1:0]    r_dat_sync;
    logic [3:0]    r_bit_cnt;
    logic [9:0]    r_shift;
    logic [TW-1:0] r_idle_cnt;
    logic          r_byte_rdy;
    logic [7:0]    r_byte_data;
    logic          r_frame_err;

    logic w_fall;
    logic w_dat;
    logic w_last_bit;
    logic w_frame_ok;
    logic w_timeout;

    assign w_fall     = r_clk_sync[2] & ~r_clk_sync[1];
    assign w_dat      = r_dat_sync[1];
    assign w_last_bit = (r_bit_cnt == 4'd10);

    // On the 11th edge r_shift holds {parity, D7..D0, start} and w_dat is stop.
    assign w_frame_ok = (r_shift[0] == 1'b0) && w_dat && (^r_shift[9:1]);

    assign w_timeout  = (r_bit_cnt != 4'd0) && !w_fall && (r_idle_cnt == T_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // Idle-high reset values so release from reset is not seen as an edge.
            r_clk_sync  <= 3'b111;
            r_dat_sync  <= 2'b11;
            r_bit_cnt   <= 4'd0;
            r_shift     <= 10'd0;
            r_idle_cnt  <= '0;
            r_byte_rdy  <= 1'b0;
            r_byte_data <= 8'h00;
            r_frame_err <= 1'b0;
        end else begin
            r_clk_sync  <= {r_clk_sync[1:0], i_ps2_clk};
            r_dat_sync  <= {r_dat_sync[0], i_ps2_data};
            r_byte_rdy  <= 1'b0;
            r_frame_err <= 1'b0;

            if (w_fall) begin
                r_idle_cnt <= '0;
                if (w_last_bit) begin
                    r_bit_cnt <= 4'd0;
                    if (w_frame_ok) begin
                        r_byte_rdy  <= 1'b1;
                        r_byte_data <= r_shift[8:1];
                    end else begin
                        r_frame_err <= 1'b1;
                    end
                end else begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                    r_shift   <= {w_dat, r_shift[9:1]};
                end
            end else if (w_timeout) begin
                r_bit_cnt   <= 4'd0;
                r_idle_cnt  <= '0;
                r_frame_err <= 1'b1;
            end else if (r_bit_cnt != 4'd0) begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end else begin
                r_idle_cnt <= '0;
            end
        end
    end

    assign o_byte_rdy  = r_byte_rdy;
    assign o_byte_data = r_byte_data;
    assign o_frame_err = r_frame_err;

endmodule

// File: rtl/ps2_key_display.sv
// ----------------------------------------------------------------------------
// ps2_key_display
// PS/2 keyboard front end plus seven-segment display driver. Decodes make,
// break and E0-extended sequences, tracks the currently held key, keeps a BCD
// count of counted key presses and drives segment patterns for the held
// scancode and for the count.
//   clk, rst    system clock, synchronous active-high reset
//   ps2_clk     PS/2 clock pin (asynchronous)
//   ps2_data    PS/2 data pin (asynchronous)
//   key_valid   1-cycle pulse on each counted make code
//   key_code    last make scancode (E0 prefix stripped)
//   key_ext     last make code was E0-prefixed
//   key_held    key_code/key_ext currently held down
//   frame_err   1-cycle pulse on a bad or timed-out frame
//   press_bcd   BCD press count, digit 0 in [3:0]
//   seg_code    {hi,lo} hex digits of key_code, {g..a}; blank when no key held
//   seg_cnt     count digits, digit 0 in [6:0], {g..a}
// ----------------------------------------------------------------------------
module ps2_key_display
    import ps2_pkg::*;
#(
    parameter int CNT_DIGITS     = 2,
    parameter int TIMEOUT_CYC    = 50000,
    parameter int IGNORE_REPEAT  = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ps2_clk,
    input  logic                    ps2_data,
    output logic                    key_valid,
    output logic [7:0]              key_code,
    output logic                    key_ext,
    output logic                    key_held,
    output logic                    frame_err,
    output logic [4*CNT_DIGITS-1:0] press_bcd,
    output logic [13:0]             seg_code,
    output logic [7*CNT_DIGITS-1:0] seg_cnt
);

    // XOR mask turning an active-high pattern into the output polarity.
    localparam logic [6:0] SEG_POL  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [6:0] SEG_ZERO = 7'h3F ^ SEG_POL;

    logic                    w_byte_rdy;
    logic [7:0]              w_byte_data;
    logic                    w_frame_err;

    dec_state_t              r_state;
    dec_state_t              w_state_nxt;
    logic                    w_make;
    logic                    w_make_ext;
    logic                    w_release;
    logic                    w_repeat;
    logic                    w_count;

    logic                    r_key_valid;
    logic [7:0]              r_key_code;
    logic                    r_key_ext;
    logic                    r_key_held;
    logic [4*CNT_DIGITS-1:0] r_bcd;
    logic [4*CNT_DIGITS-1:0] w_bcd_inc;
    logic [CNT_DIGITS-1:0]   w_carry;
    logic [13:0]             r_seg_code;
    logic [13:0]             w_seg_code_nxt;
    logic [7*CNT_DIGITS-1:0] r_seg_cnt;
    logic [7*CNT_DIGITS-1:0] w_seg_cnt_nxt;

    ps2_rx #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_ps2_clk   (ps2_clk),
        .i_ps2_data  (ps2_data),
        .o_byte_rdy  (w_byte_rdy),
        .o_byte_data (w_byte_data),
        .o_frame_err (w_frame_err)
    );

    // ------------------------------------------------------------------
    // Decode FSM: advances only on a received byte.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_make      = 1'b0;
        w_make_ext  = 1'b0;
        w_release   = 1'b0;
        if (w_byte_rdy) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_byte_data == PS2_EXT)      w_state_nxt = ST_EXT;
                    else if (w_byte_data == PS2_BRK) w_state_nxt = ST_BRK;
                    else                             w_make      = 1'b1;
                end
                ST_EXT: begin
                    if (w_byte_data == PS2_BRK) begin
                        w_state_nxt = ST_EXT_BRK;
                    end else if (w_byte_data == PS2_EXT) begin
                        w_state_nxt = ST_EXT;
                    end else begin
                        w_make      = 1'b1;
                        w_make_ext  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    // Any byte here, E0 included, is the released key's code.
                    w_release   = r_key_held && (w_byte_data == r_key_code) && !r_key_ext;
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_release   = r_key_held && (w_byte_data == r_key_code) && r_key_ext;
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Typematic repeat: same key, same prefix, still held.
    assign w_repeat = (IGNORE_REPEAT != 0) && r_key_held &&
                      (w_byte_data == r_key_code) && (w_make_ext == r_key_ext);
    assign w_count  = w_make && !w_repeat;

    // ------------------------------------------------------------------
    // BCD increment, ripple carry from digit 0 upward; all-9s wraps to 0.
    // ------------------------------------------------------------------
    assign w_carry[0] = 1'b1;
    for (genvar d = 0; d < CNT_DIGITS; d++) begin : g_bcd
        logic [3:0] w_dig;
        assign w_dig = r_bcd[4*d +: 4];
        assign w_bcd_inc[4*d +: 4] = !w_carry[d]     ? w_dig :
                                     (w_dig == 4'd9) ? 4'd0  : w_dig + 4'd1;
        if (d < CNT_DIGITS - 1) begin : g_carry
            assign w_carry[d+1] = w_carry[d] && (w_dig == 4'd9);
        end
        assign w_seg_cnt_nxt[7*d +: 7] = hex_to_seg(w_dig) ^ SEG_POL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_valid <= 1'b0;
            r_key_code  <= 8'h00;
            r_key_ext   <= 1'b0;
            r_key_held  <= 1'b0;
            r_bcd       <= '0;
        end else begin
            r_key_valid <= w_count;
            if (w_count) begin
                r_key_code <= w_byte_data;
                r_key_ext  <= w_make_ext;
                r_key_held <= 1'b1;
                r_bcd      <= w_bcd_inc;
            end else if (w_release) begin
                r_key_held <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Segment registers: one cycle behind the key/count registers.
    // ------------------------------------------------------------------
    always_comb begin
        w_seg_code_nxt = {SEG_POL, SEG_POL};
        if (r_key_held) begin
            w_seg_code_nxt = {hex_to_seg(r_key_code[7:4]) ^ SEG_POL,
                              hex_to_seg(r_key_code[3:0]) ^ SEG_POL};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg_code <= {SEG_POL, SEG_POL};
            r_seg_cnt  <= {CNT_DIGITS{SEG_ZERO}};
        end else begin
            r_seg_code <= w_seg_code_nxt;
            r_seg_cnt  <= w_seg_cnt_nxt;
        end
    end

    assign key_valid = r_key_valid;
    assign key_code  = r_key_code;
    assign key_ext   = r_key_ext;
    assign key_held  = r_key_held;
    assign frame_err = w_frame_err;
    assign press_bcd = r_bcd;
    assign seg_code  = r_seg_code;
    assign seg_cnt   = r_seg_cnt;

endmodule

// File: tb/tb_ps2_key_display.sv
// ----------------------------------------------------------------------------
// tb_ps2_key_display
// Directed bench for ps2_key_display: 50 MHz system clock, PS/2 clock driven
// with a shortened bit time and a short timeout so the wrap-around test fits.
// Active-low segment patterns used below ({g..a}, lit = 0):
//   blank 7F, "0" 40, "1" 79, "2" 24, "3" 30, "5" 12, "7" 78, "9" 10, "C" 46
// ----------------------------------------------------------------------------
module tb_ps2_key_display;

    localparam int HALF = 100;          // PS/2 half bit period, ns
    localparam int TOUT = 200;          // TIMEOUT_CYC used for the DUT

    logic        clk = 1'b0;
    logic        rst;
    logic        ps2_clk;
    logic        ps2_data;
    logic        key_valid;
    logic [7:0]  key_code;
    logic        key_ext;
    logic        key_held;
    logic        frame_err;
    logic [7:0]  press_bcd;
    logic [13:0] seg_code;
    logic [13:0] seg_cnt;

    int total = 0;
    int bad   = 0;
    int n_valid = 0;
    int n_ferr  = 0;
    int v0, f0;

    ps2_key_display #(
        .CNT_DIGITS     (2),
        .TIMEOUT_CYC    (TOUT),
        .IGNORE_REPEAT  (1),
        .SEG_ACTIVE_LOW (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ext   (key_ext),
        .key_held  (key_held),
        .frame_err (frame_err),
        .press_bcd (press_bcd),
        .seg_code  (seg_code),
        .seg_cnt   (seg_cnt)
    );

    // Clock
    always #10 clk = ~clk;

    // Pulse monitors: count high cycles of the 1-cycle pulse outputs.
    always @(posedge clk) begin
        if (key_valid) n_valid++;
        if (frame_err) n_ferr++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Drive the first nbits of a frame; a full frame is followed by an idle gap.
    task automatic send_bits(input logic [7:0] b, input logic bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            #(HALF);
            ps2_clk = 1'b0;
            #(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        if (nbits == 11) #(4*HALF);
    endtask

    task automatic send(input logic [7:0] b);
        send_bits(b, 1'b0, 11);
    endtask

    initial begin
        rst      = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        @(negedge clk);
        do_reset();

        // Reset state
        check("rst_valid", key_valid, 0);
        check("rst_code",  key_code,  8'h00);
        check("rst_ext",   key_ext,   0);
        check("rst_held",  key_held,  0);
        check("rst_ferr",  frame_err, 0);
        check("rst_bcd",   press_bcd, 8'h00);
        check("rst_segc",  seg_code,  14'h3FFF);
        check("rst_segn",  seg_cnt,   {7'h40, 7'h40});

        // 1: single make 1C
        v0 = n_valid;
        send(8'h1C);
        check("m1_pulse", n_valid - v0, 1);
        check("m1_code",  key_code,  8'h1C);
        check("m1_ext",   key_ext,   0);
        check("m1_held",  key_held,  1);
        check("m1_bcd",   press_bcd, 8'h01);
        check("m1_segc",  seg_code,  {7'h79, 7'h46});
        check("m1_segn",  seg_cnt,   {7'h40, 7'h79});

        // 2: typematic repeats then break
        v0 = n_valid;
        send(8'h1C); send(8'h1C); send(8'h1C);
        check("rep_pulse", n_valid - v0, 0);
        check("rep_bcd",   press_bcd, 8'h01);
        send(8'hF0); send(8'h1C);
        check("brk_held", key_held,  0);
        check("brk_segc", seg_code,  14'h3FFF);
        check("brk_bcd",  press_bcd, 8'h01);
        check("brk_code", key_code,  8'h1C);

        // 3: extended make and extended break
        v0 = n_valid;
        send(8'hE0); send(8'h75);
        check("ext_pulse", n_valid - v0, 1);
        check("ext_code",  key_code,  8'h75);
        check("ext_ext",   key_ext,   1);
        check("ext_held",  key_held,  1);
        check("ext_bcd",   press_bcd, 8'h02);
        check("ext_segc",  seg_code,  {7'h78, 7'h12});
        check("ext_segn",  seg_cnt,   {7'h40, 7'h24});
        send(8'hF0); send(8'h75);      // plain break must not release an E0 key
        check("ext_nrel",  key_held,  1);
        send(8'hE0); send(8'hF0); send(8'h75);
        check("ext_rel",   key_held,  0);

        // 4: parity error
        v0 = n_valid;
        f0 = n_ferr;
        send_bits(8'h29, 1'b1, 11);
        check("par_ferr",  n_ferr - f0,  1);
        check("par_pulse", n_valid - v0, 0);
        check("par_code",  key_code,  8'h75);
        check("par_ext",   key_ext,   1);
        check("par_bcd",   press_bcd, 8'h02);

        // 6a: partial frame times out, next frame decodes normally
        f0 = n_ferr;
        send_bits(8'h29, 1'b0, 5);
        #((TOUT + 100) * 20);
        check("to_ferr", n_ferr - f0, 1);
        send(8'h29);
        check("to_code", key_code,  8'h29);
        check("to_ext",  key_ext,   0);
        check("to_held", key_held,  1);
        check("to_bcd",  press_bcd, 8'h03);
        check("to_segc", seg_code,  {7'h24, 7'h10});
        check("to_segn", seg_cnt,   {7'h40, 7'h30});

        // 5: counter wrap after 99 further distinct presses from 01
        do_reset();
        v0 = n_valid;
        send(8'h10);
        check("wr_start", press_bcd, 8'h01);
        for (int i = 0; i < 99; i++) begin
            send(8'h21 + 8'(i));
            send(8'hF0);
            send(8'h21 + 8'(i));
            if (i == 97) check("wr_99", press_bcd, 8'h99);
        end
        check("wr_bcd",   press_bcd, 8'h00);
        check("wr_segn",  seg_cnt,   {7'h40, 7'h40});
        check("wr_pulse", n_valid - v0, 100);
        check("wr_held",  key_held,  0);

        // 6b: reset in the middle of a frame
        send(8'h1C);
        v0 = n_valid;
        send_bits(8'h29, 1'b0, 6);
        do_reset();
        #(4*HALF);
        check("mr_pulse", n_valid - v0, 0);
        check("mr_code",  key_code,  8'h00);
        check("mr_ext",   key_ext,   0);
        check("mr_held",  key_held,  0);
        check("mr_bcd",   press_bcd, 8'h00);
        check("mr_segc",  seg_code,  14'h3FFF);
        check("mr_segn",  seg_cnt,   {7'h40, 7'h40});
        send(8'h1C);
        check("mr_next_code", key_code,  8'h1C);
        check("mr_next_bcd",  press_bcd, 8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
